// File: rtl/ddr4_avmm_burst_responder_if.sv
// Avalon-MM burst bus between the AFU DDR4 master port and the local responder.
interface ddr4_avmm_burst_responder_if #(
  parameter int ADDR_W  = 26,
  parameter int DATA_W  = 512,
  parameter int BURST_W = 7
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0]  address;
  logic [BURST_W-1:0] burstcount;
  logic               read;
  logic               write;
  logic [DATA_W-1:0]  writedata;
  logic [BE_W-1:0]    byteenable;
  logic               waitrequest;
  logic [DATA_W-1:0]  readdata;
  logic               readdatavalid;

  modport slave (
    input  address, burstcount, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );

  modport master (
    output address, burstcount, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/ddr4_avmm_burst_responder.sv
// Block-RAM stand-in for one DDR4 bank: Avalon-MM burst slave with fixed
// two-cycle read latency, byte-lane writes, beat counters and a sticky error flag.
module ddr4_avmm_burst_responder #(
  parameter int ADDR_W  = 26,
  parameter int DATA_W  = 512,
  parameter int BURST_W = 7,
  parameter int MEM_AW  = 10
) (
  input  logic                        DDR4_USERCLK,
  input  logic                        SoftReset_n,
  ddr4_avmm_burst_responder_if.slave  avs,
  output logic [31:0]                 wr_beat_cnt,
  output logic [31:0]                 rd_beat_cnt,
  output logic                        protocol_err
);
  localparam int BE_W   = DATA_W / 8;
  localparam int DEPTH  = 1 << MEM_AW;
  localparam int STAGES = 2;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WR_BURST = 2'd1;
  localparam logic [1:0] RD_BURST = 2'd2;

  logic [1:0]          state;
  logic                rdy;
  logic [MEM_AW-1:0]   base;
  logic [BURST_W-1:0]  beat, last, bc_eff;
  logic [MEM_AW-1:0]   idx;
  logic                wr_first, rd_first, wr_next, rd_next, wr_acc, rd_acc;
  logic [STAGES:1]     vld_pipe;
  logic [BE_W-1:0][7:0] ram_q;
  logic [DATA_W-1:0]   rdata;
  logic                unused;

  assign unused = ^avs.address[ADDR_W-1:MEM_AW];

  // rdy is the synchronised reset release: low asynchronously, high one edge later
  always_ff @(posedge DDR4_USERCLK or negedge SoftReset_n) begin
    if (!SoftReset_n) rdy <= 1'b0;
    else              rdy <= 1'b1;
  end

  assign avs.waitrequest = !rdy || (state == RD_BURST);

  assign bc_eff   = (avs.burstcount == '0) ? BURST_W'(1) : avs.burstcount;
  assign wr_first = rdy && (state == IDLE) && avs.write;
  assign rd_first = rdy && (state == IDLE) && avs.read && !avs.write;
  assign wr_next  = rdy && (state == WR_BURST) && avs.write;
  assign rd_next  = rdy && (state == RD_BURST);
  assign wr_acc   = wr_first || wr_next;
  assign rd_acc   = rd_first || rd_next;

  // Single RAM port: the command address on the first beat, base+beat afterwards
  assign idx = (state == IDLE) ? avs.address[MEM_AW-1:0] : base + MEM_AW'(beat);

  always_ff @(posedge DDR4_USERCLK or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      state        <= IDLE;
      base         <= '0;
      beat         <= '0;
      last         <= '0;
      protocol_err <= 1'b0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          if (avs.write || avs.read) begin
            base <= avs.address[MEM_AW-1:0];
            beat <= BURST_W'(1);
            last <= bc_eff - BURST_W'(1);
            if (avs.burstcount == '0 || (avs.write && avs.read)) protocol_err <= 1'b1;
            if (bc_eff > BURST_W'(1)) state <= avs.write ? WR_BURST : RD_BURST;
          end
        end
        WR_BURST: begin
          if (avs.read) protocol_err <= 1'b1;
          if (avs.write) begin
            beat <= beat + BURST_W'(1);
            if (beat == last) state <= IDLE;
          end
        end
        RD_BURST: begin
          beat <= beat + BURST_W'(1);
          if (beat == last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One narrow RAM per byte lane so byteenable maps onto independent write enables
  for (genvar i = 0; i < BE_W; i++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] lane_q;

    always_ff @(posedge DDR4_USERCLK) begin
      if (wr_acc && avs.byteenable[i]) mem[idx] <= avs.writedata[i*8 +: 8];
      if (rd_acc) lane_q <= mem[idx];
    end

    assign ram_q[i] = lane_q;
  end

  always_ff @(posedge DDR4_USERCLK or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      vld_pipe    <= '0;
      rdata       <= '0;
      wr_beat_cnt <= '0;
      rd_beat_cnt <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], rd_acc};
      if (vld_pipe[1])        rdata       <= ram_q;
      if (wr_acc)             wr_beat_cnt <= wr_beat_cnt + 32'd1;
      if (vld_pipe[STAGES])   rd_beat_cnt <= rd_beat_cnt + 32'd1;
    end
  end

  assign avs.readdata      = rdata;
  assign avs.readdatavalid = vld_pipe[STAGES];
endmodule

// File: tb/tb_ddr4_avmm_burst_responder.sv
// Directed bench for ddr4_avmm_burst_responder: bursts, byte enables, wrap, back-to-back reads, bubbles, mid-burst reset.
module tb_ddr4_avmm_burst_responder;
  localparam int ADDR_W  = 26;
  localparam int DATA_W  = 512;
  localparam int BURST_W = 7;
  localparam int MEM_AW  = 10;
  localparam int BE_W    = DATA_W / 8;

  logic        gclk = 1'b0;
  logic        grst_n = 1'b0;
  logic [31:0] wr_cnt, rd_cnt;
  logic        perr;
  int          n_chk = 0, n_err = 0, cyc = 0, t = 0;
  logic [DATA_W-1:0] beat_q[$];
  int                bcyc_q[$];
  logic [DATA_W-1:0] e;

  ddr4_avmm_burst_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) bus ();

  ddr4_avmm_burst_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .MEM_AW(MEM_AW)
  ) dut (
    .DDR4_USERCLK (gclk),
    .SoftReset_n  (grst_n),
    .avs          (bus.slave),
    .wr_beat_cnt  (wr_cnt),
    .rd_beat_cnt  (rd_cnt),
    .protocol_err (perr)
  );

  always #5 gclk = ~gclk;
  always @(posedge gclk) cyc++;

  always @(negedge gclk)
    if (bus.readdatavalid === 1'b1) begin
      beat_q.push_back(bus.readdata);
      bcyc_q.push_back(cyc);
    end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [DATA_W-1:0] pat(input int s);
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = (32'(s) * 32'h0100_0193) ^ 32'(i << 8) ^ 32'hA5A5_0000;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge gclk); #1;
  endtask

  task automatic wait_ready(input string tag);
    int g = 0;
    while (bus.waitrequest !== 1'b0 && g < 50) begin
      @(posedge gclk); #2;
      g++;
    end
    if (bus.waitrequest !== 1'b0) chk({tag, "_wait"}, bus.waitrequest, 0);
  endtask

  task automatic wr_beat(input int a, input int bc, input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    bus.write = 1'b1; bus.address = ADDR_W'(a); bus.burstcount = BURST_W'(bc);
    bus.writedata = d; bus.byteenable = be;
    #1;
    wait_ready("wr");
    @(posedge gclk); #1;
    bus.write = 1'b0;
  endtask

  task automatic rd_cmd(input int a, input int bc, output int tc);
    bus.read = 1'b1; bus.address = ADDR_W'(a); bus.burstcount = BURST_W'(bc);
    #1;
    wait_ready("rd");
    tc = cyc;
    @(posedge gclk); #1;
    bus.read = 1'b0;
  endtask

  task automatic chk_beat(input string tag, input int k, input int tc, input logic [DATA_W-1:0] exp);
    if (k < beat_q.size()) begin
      chk($sformatf("%s_cyc%0d", tag, k), bcyc_q[k], tc + 2 + k);
      chk($sformatf("%s_dat%0d", tag, k), beat_q[k], exp);
    end else
      chk($sformatf("%s_missing%0d", tag, k), beat_q.size(), k + 1);
  endtask

  task automatic clr();
    beat_q.delete();
    bcyc_q.delete();
  endtask

  initial begin
    bus.read = 1'b0; bus.write = 1'b0; bus.address = '0; bus.burstcount = '0;
    bus.writedata = '0; bus.byteenable = '0;

    // reset values
    repeat (3) @(posedge gclk);
    #1;
    chk("rst_wreq", bus.waitrequest, 1);
    chk("rst_rdv", bus.readdatavalid, 0);
    chk("rst_rdata", bus.readdata, 0);
    chk("rst_wrcnt", wr_cnt, 0);
    chk("rst_rdcnt", rd_cnt, 0);
    chk("rst_perr", perr, 0);
    grst_n = 1'b1;
    #1 chk("rel_wreq_pre", bus.waitrequest, 1);
    @(posedge gclk); #2;
    chk("rel_wreq_post", bus.waitrequest, 0);
    step();

    // burst write N=4 then burst read N=4
    for (int k = 0; k < 4; k++) wr_beat(16, 4, pat(k), '1);
    clr();
    rd_cmd(16, 4, t);
    for (int k = 1; k <= 3; k++) begin
      #1 chk($sformatf("t1_wreq%0d", k), bus.waitrequest, 1);
      step();
    end
    #1 chk("t1_wreq_end", bus.waitrequest, 0);
    step();
    repeat (3) step();
    chk("t1_nbeats", beat_q.size(), 4);
    for (int k = 0; k < 4; k++) chk_beat("t1", k, t, pat(k));
    chk("t1_wrcnt", wr_cnt, 4);
    chk("t1_rdcnt", rd_cnt, 4);

    // byte enables: only low 4 bytes overwritten
    wr_beat(32, 1, '1, '1);
    wr_beat(32, 1, '0, BE_W'(64'hF));
    clr();
    rd_cmd(32, 1, t);
    repeat (3) step();
    e = '1;
    e[31:0] = 32'h0;
    chk_beat("t2", 0, t, e);

    // address wrap at the top of the RAM
    wr_beat(10'h3FE, 3, pat(100), '1);
    wr_beat(10'h3FE, 3, pat(101), '1);
    wr_beat(10'h3FE, 3, pat(102), '1);
    clr();
    rd_cmd(0, 1, t);
    repeat (3) step();
    chk_beat("t3a", 0, t, pat(102));
    clr();
    rd_cmd(10'h3FE, 2, t);
    repeat (4) step();
    chk_beat("t3b", 0, t, pat(100));
    chk_beat("t3b", 1, t, pat(101));

    // back-to-back single reads at 0..3
    for (int k = 1; k <= 3; k++) wr_beat(1, 3, pat(200 + k), '1);
    clr();
    for (int k = 0; k < 4; k++) begin
      bus.read = 1'b1; bus.address = ADDR_W'(k); bus.burstcount = BURST_W'(1);
      #1 chk($sformatf("t4_wreq%0d", k), bus.waitrequest, 0);
      if (k == 0) t = cyc;
      step();
    end
    bus.read = 1'b0;
    repeat (4) step();
    chk_beat("t4", 0, t, pat(102));
    for (int k = 1; k < 4; k++) chk_beat("t4", k, t, pat(200 + k));
    chk("t4_perr", perr, 0);

    // write burst with bubbles and a stray read
    clr();
    wr_beat(64, 4, pat(300), '1);
    wr_beat(64, 4, pat(301), '1);
    step();
    bus.read = 1'b1; bus.address = ADDR_W'(16); bus.burstcount = BURST_W'(1);
    #1 chk("t5_wreq_bubble", bus.waitrequest, 0);
    step();
    bus.read = 1'b0;
    wr_beat(64, 4, pat(302), '1);
    wr_beat(64, 4, pat(303), '1);
    repeat (3) step();
    chk("t5_noread", beat_q.size(), 0);
    chk("t5_perr", perr, 1);
    chk("t5_wrcnt", wr_cnt, 16);
    chk("t5_rdcnt", rd_cnt, 12);
    rd_cmd(64, 4, t);
    repeat (6) step();
    for (int k = 0; k < 4; k++) chk_beat("t5", k, t, pat(300 + k));

    // reset in the middle of a read burst
    for (int k = 0; k < 8; k++) wr_beat(128, 8, pat(400 + k), '1);
    clr();
    rd_cmd(128, 8, t);
    repeat (3) step();
    grst_n = 1'b0;
    #1;
    chk("t6_rdv_rst", bus.readdatavalid, 0);
    chk("t6_wreq_rst", bus.waitrequest, 1);
    chk("t6_wrcnt_rst", wr_cnt, 0);
    chk("t6_rdcnt_rst", rd_cnt, 0);
    step();
    step();
    grst_n = 1'b1;
    @(posedge gclk); #2;
    chk("t6_wreq_rel", bus.waitrequest, 0);
    @(posedge gclk); #1;
    repeat (10) step();
    chk("t6_nbeats", beat_q.size(), 2);
    chk_beat("t6", 0, t, pat(400));
    chk_beat("t6", 1, t, pat(401));
    chk("t6_perr", perr, 0);
    chk("t6_rdcnt", rd_cnt, 0);
    clr();
    rd_cmd(128, 2, t);
    repeat (4) step();
    chk_beat("t6b", 0, t, pat(400));
    chk_beat("t6b", 1, t, pat(401));
    chk("t6b_rdcnt", rd_cnt, 2);

    // burstcount 0 behaves as a single beat and flags an error
    clr();
    rd_cmd(130, 0, t);
    #1 chk("t7_wreq", bus.waitrequest, 0);
    repeat (3) step();
    chk("t7_nbeats", beat_q.size(), 1);
    chk_beat("t7", 0, t, pat(402));
    chk("t7_perr", perr, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ddr4_avmm_burst_responder.md
Name: ddr4_avmm_burst_responder

Overview:
- Avalon-MM burst slave that answers the DDR4 bank master ports driven out of the AFU.
- Stands in for one DDR4 bank in simulation and bring-up builds, backed by local block RAM.
- Accepts burst writes and burst reads, applies byte enables, and returns read data in order with fixed latency.
- Exports beat counters and a sticky protocol-error flag for debug.

Parameters:
- ADDR_W, 26, word address width; matches DDR4x_address.
- DATA_W, 512, data width; BE_W = DATA_W/8.
- BURST_W, 7, burstcount width.
- MEM_AW, 10, log2 of local RAM depth in DATA_W words. Address bits above MEM_AW-1 are ignored.

Ports:
- DDR4_USERCLK  in  1  single clock for all logic.
- SoftReset_n  in  1  asynchronous, active-low reset.
- avs_address  in  ADDR_W  word address; sampled on the first beat only.
- avs_burstcount  in  BURST_W  beats in the burst; sampled on the first beat only.
- avs_read  in  1  read command.
- avs_write  in  1  write beat valid.
- avs_writedata  in  DATA_W  write data.
- avs_byteenable  in  BE_W  per-byte write enable.
- avs_waitrequest  out  1  stall; a command or beat is accepted only when low.
- avs_readdata  out  DATA_W  read data.
- avs_readdatavalid  out  1  read beat valid.
- wr_beat_cnt  out  32  count of accepted write beats; wraps.
- rd_beat_cnt  out  32  count of returned read beats; wraps.
- protocol_err  out  1  sticky error flag, cleared only by reset.

Behaviour:
- Reset (asynchronous assert; deassert synchronised internally):
  - Output reset values: avs_waitrequest=1, avs_readdatavalid=0, avs_readdata=0, counters=0, protocol_err=0, state=IDLE.
  - avs_waitrequest drops to 0 on the first rising edge after reset release.
  - RAM contents are not reset.
- States: IDLE, WR_BURST, RD_BURST.
- IDLE, waitrequest=0:
  - write accepted at T: base=address, remaining=burstcount; beat 0 written to RAM[base]. Go to WR_BURST if burstcount>1, else stay in IDLE.
  - read accepted at T: base=address, N=burstcount; RAM address base issued at T. Go to RD_BURST if N>1.
  - read and write both high: write is taken, read is ignored, protocol_err set.
  - burstcount=0: treated as 1, protocol_err set.
- WR_BURST, waitrequest=0:
  - Each cycle with write=1 writes beat k to RAM[base+k]. A cycle with write=0 is a bubble, with no effect.
  - read=1 in this state is ignored and sets protocol_err.
  - After the last beat, return to IDLE.
- RD_BURST, waitrequest=1:
  - Issues one RAM address per cycle: base+1 at T+1 through base+N-1 at T+N-1.
  - Returns to IDLE at T+N; a new command can be accepted at T+N.
  - A read of N=1 never raises waitrequest, so back-to-back single reads are accepted every cycle.
- Read return timing:
  - 2-cycle registered pipeline: RAM read register, then output register.
  - Beat k is valid with readdatavalid=1 at T+2+k, contiguous, with no gaps.
  - The pipeline keeps draining while a new command is accepted.
- Byte enables: only bytes with byteenable[i]=1 are written; the other bytes keep their old contents.
- Read-during-write to the same RAM word returns the old data. Not reachable in-protocol, because the state machine serialises bursts.
- Address arithmetic: RAM index = (base+k) mod 2^MEM_AW, so it wraps silently at the top of the RAM.
- Counters:
  - wr_beat_cnt increments once per accepted write beat.
  - rd_beat_cnt increments once per cycle with readdatavalid=1.
  - Both wrap modulo 2^32.
- Reset mid-operation: the burst is aborted, readdatavalid is forced to 0 immediately, and no partial beats are returned after reset release.

Test Plan:
- Write burst N=4 at addr 0x010, data D0..D3, byteenable all ones; then read N=4 at 0x010 accepted at T → readdatavalid high T+2..T+5 returning D0..D3; waitrequest high T+1..T+3; wr_beat_cnt=4, rd_beat_cnt=4.
- Fill word 0x020 with all 0xFF; write 0 with byteenable=0x...000F; read back → low 4 bytes 0x00, remaining bytes 0xFF.
- MEM_AW=10: write N=3 at 0x3FE with A, B, C; read N=1 at 0x000 → returns C.
- Four back-to-back N=1 reads, one per cycle, at 0, 1, 2, 3 → waitrequest stays 0; readdatavalid on 4 consecutive cycles, in order.
- Write burst N=4 with write deasserted for 2 cycles after beat 1, and read=1 asserted during one bubble → all 4 beats stored correctly; read ignored; protocol_err=1.
- Read N=8 accepted, SoftReset_n asserted at T+4 for 2 cycles → readdatavalid=0 from the assertion edge onward, no further beats; counters=0; waitrequest=0 one cycle after release; a subsequent read returns the pre-reset RAM data.
